top_cfg_driver: RTL and testbench

Command-driven initiator for the `top` load and image-input interface. It turns a stream of configuration and image commands into the encoded writes that `top` samples: the packed image-bus fields plus the `kernel_layer`/`offset_layer` strobes. It also runs the `image_in_valid`/`image_in_ready` handshake. It sits between a host or ROM command source and `top`, and takes over the weight-load sequence that is currently hand-driven in simulation.

---
 rtl/top_cfg_driver.sv | 232 +++++++++++++++++++++++
 tb/tb_top_cfg_driver.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_cfg_driver.sv
`default_nettype none
// ============================================================================
// Module      : top_cfg_driver
// Description : Turns configuration/image commands into encoded image-bus
//               writes, kernel/offset strobes and the image handshake for top.
// Revision    : 1.0 - initial release
// ============================================================================
module top_cfg_driver #(
    parameter int IMG_W    = 28,
    parameter int FC_IN    = 960,
    parameter int FC_NODES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [10:0]              cmd_idx,
    input  logic [8:0]               cmd_val,
    input  logic [FC_IN-1:0]         cmd_bits,
    output logic [IMG_W*IMG_W-1:0]   image,
    output logic [1:0]               kernel_layer,
    output logic [1:0]               offset_layer,
    output logic                     image_in_valid,
    input  logic                     image_in_ready,
    output logic                     busy,
    output logic                     err
);

    localparam int IMG_BITS = IMG_W * IMG_W;
    localparam int IW       = $clog2(FC_IN);
    localparam int ROW3     = 3 * IMG_W;
    localparam int ROW4     = 4 * IMG_W;
    localparam int ROW5     = 5 * IMG_W;
    localparam int ROW6     = 6 * IMG_W;
    localparam int ROW7     = 7 * IMG_W;
    localparam int ROW8     = 8 * IMG_W;

    localparam logic [2:0] OP_C1_KERNEL = 3'd0;
    localparam logic [2:0] OP_C2_KERNEL = 3'd1;
    localparam logic [2:0] OP_C1_BIAS   = 3'd2;
    localparam logic [2:0] OP_C2_BIAS   = 3'd3;
    localparam logic [2:0] OP_FC_BIAS   = 3'd4;
    localparam logic [2:0] OP_FC_ROW    = 3'd5;
    localparam logic [2:0] OP_IMAGE     = 3'd6;

    localparam logic [IW-1:0] I_LAST = IW'(FC_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_FC_ROW = 2'd2,
        S_IMG    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IMG_BITS-1:0] image_q, image_d;
    logic [1:0]          kl_q, kl_d;
    logic [1:0]          ol_q, ol_d;
    logic                err_q, err_d;
    logic [FC_IN-1:0]    bits_q, bits_d;
    logic [3:0]          node_q, node_d;
    logic [IW-1:0]       i_q, i_d;

    logic                idx_ok;
    logic [IMG_BITS-1:0] cfg_bus;
    logic [1:0]          cfg_kl;
    logic [1:0]          cfg_ol;
    logic [2:0]          idx_mod5;
    logic [4:0]          idx_div5;
    logic [4:0]          idx_mod18;
    logic [5:0]          idx_div18;

    // One FC weight write: node on row 6, column counter on row 8, weight bit on row 3.
    function automatic logic [IMG_BITS-1:0] fc_word(input logic [3:0]    node,
                                                    input logic [IW-1:0] i,
                                                    input logic          wbit);
        logic [IMG_BITS-1:0] w;
        w              = '0;
        w[ROW6 +: 4]   = node;
        w[ROW8 +: IW]  = i;
        w[ROW3]        = wbit;
        return w;
    endfunction

    always_comb begin
        idx_ok = 1'b0;
        case (cmd_op)
            OP_C1_KERNEL: idx_ok = (cmd_idx < 11'd90);
            OP_C2_KERNEL: idx_ok = (cmd_idx < 11'd1080);
            OP_C1_BIAS:   idx_ok = (cmd_idx < 11'd18);
            OP_C2_BIAS:   idx_ok = (cmd_idx < 11'd60);
            OP_FC_BIAS:   idx_ok = (cmd_idx < 11'd10);
            OP_FC_ROW:    idx_ok = (cmd_idx < 11'(FC_NODES));
            OP_IMAGE:     idx_ok = 1'b1;
            default:      idx_ok = 1'b0;
        endcase
    end

    always_comb begin
        idx_mod5  = 3'(cmd_idx % 11'd5);
        idx_div5  = 5'(cmd_idx / 11'd5);
        idx_mod18 = 5'(cmd_idx % 11'd18);
        idx_div18 = 6'(cmd_idx / 11'd18);
    end

    // Single-cycle config words: cleared bus with only the op's fields set.
    always_comb begin
        cfg_bus = '0;
        cfg_kl  = 2'd0;
        cfg_ol  = 2'd0;
        case (cmd_op)
            OP_C1_KERNEL: begin
                cfg_bus[24:0]      = cmd_bits[24:0];
                cfg_bus[ROW5 +: 3] = idx_mod5;
                cfg_bus[ROW4 +: 5] = idx_div5;
                cfg_kl             = 2'd1;
            end
            OP_C2_KERNEL: begin
                cfg_bus[24:0]      = cmd_bits[24:0];
                cfg_bus[ROW4 +: 5] = idx_mod18;
                cfg_bus[ROW7 +: 6] = idx_div18;
                cfg_kl             = 2'd2;
            end
            OP_C1_BIAS: begin
                cfg_bus[ROW3 +: 7] = cmd_val[6:0];
                cfg_bus[ROW4 +: 6] = cmd_idx[5:0];
                cfg_ol             = 2'd1;
            end
            OP_C2_BIAS: begin
                cfg_bus[ROW3 +: 9] = cmd_val;
                cfg_bus[ROW7 +: 6] = cmd_idx[5:0];
                cfg_ol             = 2'd2;
            end
            OP_FC_BIAS: begin
                cfg_bus[ROW3 +: 8] = cmd_val[7:0];
                cfg_bus[ROW6 +: 4] = cmd_idx[3:0];
                cfg_ol             = 2'd3;
            end
            default: begin
                cfg_bus = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        image_d = image_q;
        kl_d    = 2'd0;
        ol_d    = 2'd0;
        err_d   = 1'b0;
        bits_d  = bits_q;
        node_d  = node_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!idx_ok) begin
                        err_d = 1'b1;
                    end else if (cmd_op == OP_IMAGE) begin
                        image_d = cmd_bits[IMG_BITS-1:0];
                        state_d = S_IMG;
                    end else if (cmd_op == OP_FC_ROW) begin
                        bits_d  = cmd_bits;
                        node_d  = cmd_idx[3:0];
                        i_d     = '0;
                        image_d = fc_word(cmd_idx[3:0], '0, cmd_bits[0]);
                        kl_d    = 2'd3;
                        state_d = S_FC_ROW;
                    end else begin
                        image_d = cfg_bus;
                        kl_d    = cfg_kl;
                        ol_d    = cfg_ol;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_FC_ROW: begin
                if (i_q == I_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    i_d     = i_q + IW'(1);
                    image_d = fc_word(node_q, i_d, bits_q[i_d]);
                    kl_d    = 2'd3;
                end
            end
            S_IMG: begin
                if (image_in_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            image_q <= '0;
            kl_q    <= 2'd0;
            ol_q    <= 2'd0;
            err_q   <= 1'b0;
            bits_q  <= '0;
            node_q  <= 4'd0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            image_q <= image_d;
            kl_q    <= kl_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
            node_q  <= node_d;
            i_q     <= i_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign image_in_valid = (state_q == S_IMG);
    assign image          = image_q;
    assign kernel_layer   = kl_q;
    assign offset_layer   = ol_q;
    assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_top_cfg_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_cfg_driver
// Description : Directed bench for top_cfg_driver with a command-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_cfg_driver;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [10:0]  cmd_idx;
    logic [8:0]   cmd_val;
    logic [959:0] cmd_bits;
    logic [783:0] image;
    logic [1:0]   kernel_layer;
    logic [1:0]   offset_layer;
    logic         image_in_valid;
    logic         image_in_ready;
    logic         busy;
    logic         err;

    int checks   = 0;
    int failures = 0;

    top_cfg_driver dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_idx        (cmd_idx),
        .cmd_val        (cmd_val),
        .cmd_bits       (cmd_bits),
        .image          (image),
        .kernel_layer   (kernel_layer),
        .offset_layer   (offset_layer),
        .image_in_valid (image_in_valid),
        .image_in_ready (image_in_ready),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command-level model: each accepted command expands into a list of bus writes.
    typedef struct packed {
        logic [783:0] bus;
        logic [1:0]   kl;
        logic [1:0]   ol;
    } wr_t;

    wr_t          wq[$];
    wr_t          m_w;
    logic [783:0] m_image = '0;
    logic [1:0]   m_kl    = 2'd0;
    logic [1:0]   m_ol    = 2'd0;
    logic         m_err   = 1'b0;
    logic         m_img   = 1'b0;
    logic         m_acc;
    logic         m_ready;

    assign m_ready = (m_kl == 2'd0) && (m_ol == 2'd0) && !m_img;

    function automatic logic [783:0] put(input logic [783:0] bus, input int row,
                                         input int width, input int v);
        for (int k = 0; k < width; k++) bus[row*28 + k] = v[k];
        return bus;
    endfunction

    function automatic bit legal(input int op, input int idx);
        case (op)
            0: return idx < 90;
            1: return idx < 1080;
            2: return idx < 18;
            3: return idx < 60;
            4: return idx < 10;
            5: return idx < 10;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic wr_t cfg_write(input int op, input int idx, input int val,
                                      input logic [959:0] b);
        wr_t w;
        w = '0;
        case (op)
            0: begin
                w.bus[24:0] = b[24:0];
                w.bus = put(w.bus, 5, 3, idx % 5);
                w.bus = put(w.bus, 4, 5, idx / 5);
                w.kl  = 2'd1;
            end
            1: begin
                w.bus[24:0] = b[24:0];
                w.bus = put(w.bus, 4, 5, idx % 18);
                w.bus = put(w.bus, 7, 6, idx / 18);
                w.kl  = 2'd2;
            end
            2: begin
                w.bus = put(w.bus, 3, 7, val);
                w.bus = put(w.bus, 4, 6, idx);
                w.ol  = 2'd1;
            end
            3: begin
                w.bus = put(w.bus, 3, 9, val);
                w.bus = put(w.bus, 7, 6, idx);
                w.ol  = 2'd2;
            end
            4: begin
                w.bus = put(w.bus, 3, 8, val);
                w.bus = put(w.bus, 6, 4, idx);
                w.ol  = 2'd3;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            wq.delete();
            m_image = '0;
            m_kl    = 2'd0;
            m_ol    = 2'd0;
            m_err   = 1'b0;
            m_img   = 1'b0;
        end else begin
            m_acc = cmd_valid && m_ready;
            m_err = 1'b0;
            if (m_img && image_in_ready) m_img = 1'b0;
            if (m_acc) begin
                if (!legal(int'(cmd_op), int'(cmd_idx))) begin
                    m_err = 1'b1;
                end else if (cmd_op == 3'd6) begin
                    m_image = cmd_bits[783:0];
                    m_img   = 1'b1;
                end else if (cmd_op == 3'd5) begin
                    for (int i = 0; i < 960; i++) begin
                        m_w     = '0;
                        m_w.bus = put(m_w.bus, 6, 4, int'(cmd_idx));
                        m_w.bus = put(m_w.bus, 8, 10, i);
                        m_w.bus[3*28] = cmd_bits[i];
                        m_w.kl  = 2'd3;
                        wq.push_back(m_w);
                    end
                end else begin
                    wq.push_back(cfg_write(int'(cmd_op), int'(cmd_idx), int'(cmd_val), cmd_bits));
                end
            end
            if (wq.size() > 0) begin
                m_w     = wq.pop_front();
                m_image = m_w.bus;
                m_kl    = m_w.kl;
                m_ol    = m_w.ol;
            end else begin
                m_kl = 2'd0;
                m_ol = 2'd0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (image !== m_image) begin
                failures++;
                $display("FAIL model_image t=%0t got=%h exp=%h", $time, image, m_image);
            end
            checks++;
            if ({kernel_layer, offset_layer, err, cmd_ready, busy, image_in_valid} !==
                {m_kl, m_ol, m_err, m_ready, !m_ready, m_img}) begin
                failures++;
                $display("FAIL model_ctrl t=%0t got kl/ol/err/rdy/busy/vld=%b exp=%b", $time,
                         {kernel_layer, offset_layer, err, cmd_ready, busy, image_in_valid},
                         {m_kl, m_ol, m_err, m_ready, !m_ready, m_img});
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Presents a command and returns #1 into the cycle after it was accepted.
    task automatic send(input logic [2:0] op, input logic [10:0] idx,
                        input logic [8:0] val, input logic [959:0] b);
        int n;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_val   = val;
        cmd_bits  = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready_timeout", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    logic [959:0] row;
    logic [959:0] pic;
    logic [959:0] kbits;
    logic [783:0] exp_b;
    int           cnt;

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_op         = 3'd0;
        cmd_idx        = 11'd0;
        cmd_val        = 9'd0;
        cmd_bits       = '0;
        image_in_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            row[k*32 +: 32] = $urandom;
            pic[k*32 +: 32] = $urandom;
        end

        // Reset state
        @(posedge clk); #1;
        chk("reset_image_zero", {63'd0, image == '0}, 64'd1);
        chk("reset_ctrl", {56'd0, kernel_layer, offset_layer, image_in_valid, err, busy, 1'b0}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("release_ready", {63'd0, cmd_ready}, 64'd1);

        // Full FC row, node 9
        send(3'd5, 11'd9, 9'd0, row);
        cmd_valid = 1'b0;
        cnt = 0;
        while (kernel_layer == 2'd3 && cnt < 1000) begin
            chk("fc_i", {54'd0, image[224 +: 10]}, 64'(cnt));
            chk("fc_bit", {63'd0, image[84]}, {63'd0, row[cnt]});
            chk("fc_node", {60'd0, image[168 +: 4]}, 64'd9);
            cnt++;
            @(posedge clk); #1;
        end
        chk("fc_strobe_cycles", 64'(cnt), 64'd960);
        chk("fc_idle_after", {62'd0, busy, cmd_ready}, 64'd1);

        // Reset in the middle of an FC row at i=300
        send(3'd5, 11'd4, 9'd0, pic);
        cmd_valid = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("fc_mid_i300", {54'd0, image[224 +: 10]}, 64'd300);
        #2 rst = 1'b1;
        #1;
        chk("midrst_image_zero", {63'd0, image == '0}, 64'd1);
        chk("midrst_ctrl", {58'd0, kernel_layer, offset_layer, image_in_valid, err}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // conv1_kernel idx 23 immediately after release
        kbits = '0;
        kbits[24:0] = 25'h1555555;
        send(3'd0, 11'd23, 9'd0, kbits);
        cmd_valid = 1'b0;
        chk("c1k_strobe", {60'd0, kernel_layer, offset_layer}, 64'h4);
        chk("c1k_bits", {39'd0, image[24:0]}, 64'h1555555);
        chk("c1k_row5", {61'd0, image[142:140]}, 64'd3);
        chk("c1k_row4", {59'd0, image[116:112]}, 64'd4);
        chk("c1k_popcount", 64'($countones(image)), 64'd16);
        chk("model_c1k_row5", {61'd0, m_image[142:140]}, 64'd3);
        @(posedge clk); #1;
        chk("c1k_strobe_drop", {60'd0, kernel_layer, offset_layer}, 64'd0);
        chk("c1k_bus_hold", {39'd0, image[24:0]}, 64'h1555555);
        chk("c1k_ready_back", {63'd0, cmd_ready}, 64'd1);

        // conv2_kernel 1079 then conv2_bias 59 back-to-back
        send(3'd1, 11'd1079, 9'd0, row);
        chk("c2k_strobe", {62'd0, kernel_layer}, 64'd2);
        chk("c2k_ready_low", {63'd0, cmd_ready}, 64'd0);
        chk("c2k_row4", {59'd0, image[116:112]}, 64'd17);
        chk("c2k_row7", {58'd0, image[201:196]}, 64'd59);
        chk("model_c2k_row7", {58'd0, m_image[201:196]}, 64'd59);
        send(3'd3, 11'd59, 9'h1A5, row);
        cmd_valid = 1'b0;
        chk("c2b_strobe", {60'd0, kernel_layer, offset_layer}, 64'd2);
        chk("c2b_ready_low", {63'd0, cmd_ready}, 64'd0);
        chk("c2b_val", {55'd0, image[92:84]}, 64'h1A5);
        chk("c2b_row7", {58'd0, image[201:196]}, 64'd59);
        exp_b = '0;
        exp_b[92:84]   = 9'h1A5;
        exp_b[201:196] = 6'd59;
        chk("c2b_bus_exact", {63'd0, image == exp_b}, 64'd1);

        // Rejected commands: conv1_bias idx 18, then op 7
        @(posedge clk); #1;
        send(3'd2, 11'd18, 9'h07F, row);
        chk("rej1_err", {63'd0, err}, 64'd1);
        chk("rej1_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rej1_strobe", {60'd0, kernel_layer, offset_layer}, 64'd0);
        chk("rej1_bus", {63'd0, image == exp_b}, 64'd1);
        send(3'd7, 11'd0, 9'd0, row);
        cmd_valid = 1'b0;
        chk("rej2_err", {63'd0, err}, 64'd1);
        chk("rej2_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rej2_bus", {63'd0, image == exp_b}, 64'd1);
        @(posedge clk); #1;
        chk("rej_err_drop", {63'd0, err}, 64'd0);

        // fc_bias idx 9, val with bit 8 set (bit 8 must not appear)
        send(3'd4, 11'd9, 9'h1FF, row);
        cmd_valid = 1'b0;
        chk("fcb_strobe", {60'd0, kernel_layer, offset_layer}, 64'd3);
        chk("fcb_val", {55'd0, image[92:84]}, 64'h0FF);
        chk("fcb_idx", {60'd0, image[171:168]}, 64'd9);
        @(posedge clk); #1;

        // Image with ready held low for 7 cycles
        image_in_ready = 1'b0;
        send(3'd6, 11'd0, 9'd0, pic);
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("img_valid_hold", {63'd0, image_in_valid}, 64'd1);
            chk("img_bus_stable", {63'd0, image == pic[783:0]}, 64'd1);
            @(posedge clk); #1;
        end
        image_in_ready = 1'b1;
        chk("img_valid_at_ready", {63'd0, image_in_valid}, 64'd1);
        @(posedge clk); #1;
        image_in_ready = 1'b0;
        chk("img_done", {62'd0, image_in_valid, busy}, 64'd0);
        chk("img_done_ready", {63'd0, cmd_ready}, 64'd1);

        // Image with ready already high
        image_in_ready = 1'b1;
        send(3'd6, 11'd0, 9'd0, row);
        cmd_valid = 1'b0;
        chk("img_fast_valid", {63'd0, image_in_valid}, 64'd1);
        @(posedge clk); #1;
        image_in_ready = 1'b0;
        chk("img_fast_done", {62'd0, image_in_valid, busy}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
